// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter in front of one Avalon-style memory slave.
// Ports: clk, reset (async, active-high); m0_*/m1_* master sides
//   (address, read, write, writedata, byteenable in; waitrequest,
//   readdata out); slave side address/read/write/writedata/byteenable
//   out, waitrequest/readdata in.
module mips_bus_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_CONSEC = 4,
   localparam int BE_W      = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic [BE_W-1:0]   m0_byteenable,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic [BE_W-1:0]   m1_byteenable,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   output logic [DATA_W-1:0] writedata,
   output logic [BE_W-1:0]   byteenable,
   input  logic              waitrequest,
   input  logic [DATA_W-1:0] readdata
);

   localparam int CW = $clog2(MAX_CONSEC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GNT0,
      S_GNT1
   } state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [CW-1:0] consec_q, consec_d;

   logic   req0, req1;
   logic   gnt1;
   logic   own_req, oth_req;
   logic   at_limit;
   state_t oth_st;

   assign req0     = m0_read | m0_write;
   assign req1     = m1_read | m1_write;
   assign gnt1     = (state_q == S_GNT1);
   assign own_req  = gnt1 ? req1 : req0;
   assign oth_req  = gnt1 ? req0 : req1;
   assign oth_st   = gnt1 ? S_GNT0 : S_GNT1;
   assign at_limit = (int'(consec_q) + 1 >= MAX_CONSEC);

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      consec_d = consec_q;
      case (state_q)
         S_IDLE: begin
            // On a tie the master that did not own the bus last wins.
            if (req0 && (!req1 || last_q)) state_d = S_GNT0;
            else if (req1)                  state_d = S_GNT1;
         end
         S_GNT0, S_GNT1: begin
            if (own_req && !waitrequest) begin
               last_d = gnt1;
               if (oth_req && at_limit) begin
                  state_d  = oth_st;
                  consec_d = '0;
               end else if (consec_q != CW'(MAX_CONSEC)) begin
                  // Saturate so a long solo run cannot wrap the count
                  // and extend the lock once the other side shows up.
                  consec_d = consec_q + 1'b1;
               end
            end else if (!own_req) begin
               state_d  = S_IDLE;
               last_d   = gnt1;
               consec_d = '0;
            end
         end
         default: begin
            state_d  = S_IDLE;
            consec_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         last_q   <= 1'b1;
         consec_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         consec_q <= consec_d;
      end
   end

   always_comb begin
      address    = '0;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      byteenable = '0;
      case (state_q)
         S_GNT0: begin
            address    = m0_address;
            read       = m0_read;
            write      = m0_write;
            writedata  = m0_writedata;
            byteenable = m0_byteenable;
         end
         S_GNT1: begin
            address    = m1_address;
            read       = m1_read;
            write      = m1_write;
            writedata  = m1_writedata;
            byteenable = m1_byteenable;
         end
         default: ;
      endcase
   end

   assign m0_waitrequest = (state_q != S_GNT0) | waitrequest;
   assign m1_waitrequest = (state_q != S_GNT1) | waitrequest;
   assign m0_readdata    = readdata;
   assign m1_readdata    = readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: directed scenarios plus random traffic
// compared every cycle against a transfer-level arbitration model.
module tb_mips_bus_arbiter;

   localparam int MAXC = 4;

   logic        clk, reset;
   logic [31:0] m0_address, m1_address, address;
   logic        m0_read, m0_write, m1_read, m1_write, read, write;
   logic [31:0] m0_writedata, m1_writedata, writedata;
   logic [3:0]  m0_byteenable, m1_byteenable, byteenable;
   logic        m0_waitrequest, m1_waitrequest, waitrequest;
   logic [31:0] m0_readdata, m1_readdata, readdata;

   mips_bus_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_CONSEC(MAXC)
   ) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m1_address(m1_address), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // master-side transaction state
   bit          act[2];
   bit          rq_r[2], rq_w[2];
   logic [31:0] ad[2], wd[2];
   logic [3:0]  be[2];

   // arbitration model: owner -1 none, 0/1 granted master
   int own, mlast, mcnt;
   bit done[2];

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      own = -1; mlast = 1; mcnt = 0;
      done[0] = 0; done[1] = 0;
   endtask

   task automatic model_step();
      bit r[2];
      int x, o;
      r[0] = m0_read | m0_write;
      r[1] = m1_read | m1_write;
      done[0] = 0; done[1] = 0;
      if (reset) begin
         model_reset();
      end else if (own < 0) begin
         if (r[0] && r[1]) own = (mlast == 1) ? 0 : 1;
         else if (r[0])    own = 0;
         else if (r[1])    own = 1;
      end else begin
         x = own; o = 1 - x;
         if (r[x] && !waitrequest) begin
            done[x] = 1;
            mlast = x;
            if (r[o] && mcnt + 1 >= MAXC) begin
               own = o; mcnt = 0;
            end else if (mcnt < MAXC) begin
               mcnt++;
            end
         end else if (!r[x]) begin
            own = -1; mlast = x; mcnt = 0;
         end
      end
   endtask

   task automatic drive();
      m0_read = act[0] & rq_r[0];  m0_write = act[0] & rq_w[0];
      m1_read = act[1] & rq_r[1];  m1_write = act[1] & rq_w[1];
      m0_address = ad[0]; m0_writedata = wd[0]; m0_byteenable = be[0];
      m1_address = ad[1]; m1_writedata = wd[1]; m1_byteenable = be[1];
   endtask

   task automatic check_outputs();
      logic [31:0] ea, ew;
      logic [3:0]  eb;
      logic        er, ewr;
      ea = '0; ew = '0; eb = '0; er = 0; ewr = 0;
      if (own == 0) begin
         ea = m0_address; ew = m0_writedata; eb = m0_byteenable;
         er = m0_read; ewr = m0_write;
      end else if (own == 1) begin
         ea = m1_address; ew = m1_writedata; eb = m1_byteenable;
         er = m1_read; ewr = m1_write;
      end
      chk("address", address, ea);
      chk("writedata", writedata, ew);
      chk("byteenable", byteenable, eb);
      chk("read", read, er);
      chk("write", write, ewr);
      chk("m0_wait", m0_waitrequest, (own != 0) | waitrequest);
      chk("m1_wait", m1_waitrequest, (own != 1) | waitrequest);
      chk("m0_rdata", m0_readdata, readdata);
      chk("m1_rdata", m1_readdata, readdata);
   endtask

   task automatic gen();
      int op;
      for (int m = 0; m < 2; m++) begin
         if (act[m] && done[m]) act[m] = 0;
         if (!act[m] && $urandom_range(0, 3) != 0) begin
            act[m] = 1;
            op = $urandom_range(0, 5);
            rq_r[m] = (op < 3) || (op == 5);
            rq_w[m] = (op >= 3);
            ad[m] = $urandom; wd[m] = $urandom;
            be[m] = 4'($urandom);
         end
      end
      waitrequest = ($urandom_range(0, 2) == 0);
      readdata = $urandom;
   endtask

   task automatic dc(input bit rnd);
      @(negedge clk);
      if (rnd) gen();
      drive();
      #1 check_outputs();
   endtask

   task automatic tk();
      @(posedge clk);
      model_step();
   endtask

   task automatic set_m(input int m, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
      act[m] = 1; rq_r[m] = r; rq_w[m] = w;
      ad[m] = a; wd[m] = d; be[m] = b;
   endtask

   task automatic pulse_reset();
      #2 reset = 1;
      model_reset();
      act[0] = 0; act[1] = 0;
      dc(0);
      tk();
      #2 reset = 0;
   endtask

   initial begin
      int g;
      reset = 1; waitrequest = 0; readdata = '0;
      act[0] = 0; act[1] = 0;
      for (int m = 0; m < 2; m++) begin
         rq_r[m] = 0; rq_w[m] = 0; ad[m] = '0; wd[m] = '0; be[m] = '0;
      end
      model_reset();
      drive();

      // reset state
      dc(0);
      chk("rst_m0_wait", m0_waitrequest, 1);
      chk("rst_m1_wait", m1_waitrequest, 1);
      chk("rst_read", read, 0);
      tk();
      #2 reset = 0;

      // single m0 read, zero-wait slave
      set_m(0, 1, 0, 32'hBFC0_0000, 0, 4'hF);
      dc(0);
      chk("t1_arb_wait", m0_waitrequest, 1);
      chk("t1_arb_read", read, 0);
      tk();
      dc(0);
      chk("t1_read", read, 1);
      chk("t1_addr", address, 32'hBFC0_0000);
      chk("t1_m0_wait", m0_waitrequest, 0);
      chk("t1_m1_wait", m1_waitrequest, 1);
      tk();
      act[0] = 0;
      readdata = 32'h1234_5678;
      dc(0);
      chk("t1_bcast", m1_readdata, 32'h1234_5678);
      tk();
      dc(0); tk();

      // simultaneous request out of reset: m0 first
      pulse_reset();
      set_m(0, 1, 0, 32'h100, 0, 4'hF);
      set_m(1, 1, 0, 32'h200, 0, 4'hF);
      dc(0);
      chk("t2_idle_m0", m0_waitrequest, 1);
      chk("t2_idle_m1", m1_waitrequest, 1);
      tk();
      dc(0);
      chk("t2_g0_m0", m0_waitrequest, 0);
      chk("t2_g0_m1", m1_waitrequest, 1);
      chk("t2_g0_addr", address, 32'h100);
      tk();
      act[0] = 0;
      dc(0); tk();
      dc(0); tk();
      dc(0);
      chk("t2_g1_m1", m1_waitrequest, 0);
      chk("t2_g1_addr", address, 32'h200);
      tk();
      act[1] = 0;
      dc(0); tk();

      // continuous contention: 4 x m0, 4 x m1, 4 x m0
      set_m(0, 1, 0, 32'h300, 0, 4'hF);
      set_m(1, 0, 1, 32'h400, 32'h55, 4'hF);
      dc(0); tk();
      for (int i = 0; i < 12; i++) begin
         dc(0);
         g = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 2);
         chk("t3_rr", g, (i / 4) % 2);
         tk();
      end
      act[0] = 0; act[1] = 0;
      dc(0); tk();

      // stalled m0 write holds the slave bus while m1 waits
      set_m(0, 0, 1, 32'hA0, 32'hDEAD_BEEF, 4'b0011);
      set_m(1, 1, 0, 32'hB0, 0, 4'hF);
      dc(0); tk();
      waitrequest = 1;
      for (int i = 0; i < 3; i++) begin
         dc(0);
         chk("t4_addr", address, 32'hA0);
         chk("t4_wdata", writedata, 32'hDEAD_BEEF);
         chk("t4_be", byteenable, 4'b0011);
         chk("t4_write", write, 1);
         chk("t4_m1_wait", m1_waitrequest, 1);
         tk();
      end
      waitrequest = 0;
      dc(0);
      chk("t4_done", m0_waitrequest, 0);
      tk();
      act[0] = 0;
      dc(0); tk();
      dc(0); tk();
      dc(0);
      chk("t4_m1_gnt", m1_waitrequest, 0);
      chk("t4_m1_addr", address, 32'hB0);
      tk();
      act[1] = 0;
      dc(0); tk();

      // reset during a stalled m1 read
      set_m(1, 1, 0, 32'hC0, 0, 4'hF);
      waitrequest = 1;
      dc(0); tk();
      dc(0);
      chk("t5_read_on", read, 1);
      #2 reset = 1;
      model_reset();
      #1;
      chk("t5_read_off", read, 0);
      chk("t5_write_off", write, 0);
      chk("t5_m1_wait", m1_waitrequest, 1);
      tk();
      #2 reset = 0;
      waitrequest = 0;
      set_m(0, 1, 0, 32'hD0, 0, 4'hF);
      dc(0); tk();
      dc(0);
      chk("t5_m0_gnt", m0_waitrequest, 0);
      chk("t5_m1_hold", m1_waitrequest, 1);
      tk();
      act[0] = 0; act[1] = 0;
      dc(0); tk();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         dc(1);
         tk();
         if ($urandom_range(0, 499) == 0) pulse_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
